// File: rtl/spi_imu_pkg.sv
// Shared types and constants for the SPI IMU responder.
// Holds the FSM state type, the RW bit meaning and the default WHOAMI identity.
package spi_imu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic       RW_READ         = 1'b1;
  localparam logic [6:0] WHOAMI_ADDR_DEF = 7'h0F;
  localparam logic [7:0] WHOAMI_VAL_DEF  = 8'h68;

endpackage

// File: rtl/spi_imu_responder_edge_sync.sv
// Two-flop synchroniser with single-cycle rise/fall pulses taken from the synchronised level.
// RST_VAL sets the level the synchroniser assumes while in reset.
module edge_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign q    = sync_r;
  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_imu_responder.sv
// SPI mode-3 peripheral emulating the IMU: byte register file read/written by the master,
// with a host port that loads sensor bytes for closed-loop testing.
module spi_imu_responder
  import spi_imu_pkg::*;
#(
  parameter int         NREGS       = 16,
  parameter logic [6:0] WHOAMI_ADDR = WHOAMI_ADDR_DEF,
  parameter logic [7:0] WHOAMI_VAL  = WHOAMI_VAL_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     sclk,
  input  logic                     sdi,
  output logic                     sdo,
  output logic                     sdo_oe,
  input  logic                     host_we,
  input  logic [$clog2(NREGS)-1:0] host_addr,
  input  logic [7:0]               host_wdata,
  output logic                     wr_valid,
  output logic [6:0]               wr_addr,
  output logic [7:0]               wr_data,
  output logic                     frame_done
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [7:0] NREGS_W = 8'(NREGS);

  logic cs_lvl_unused, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic sdi_s, sdi_rise_unused, sdi_fall_unused;

  // cs resets low so a frame already in progress at reset is ignored until cs goes high then low
  edge_sync #(.RST_VAL(1'b0)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs), .q(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );
  edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk), .q(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  edge_sync #(.RST_VAL(1'b0)) u_sdi_sync (
    .clk(clk), .reset(reset), .din(sdi), .q(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
  );

  state_t     state_r, state_next;
  logic [2:0] bit_cnt_r;
  logic [6:0] addr_r;
  logic       rw_r;
  logic       byte_seen_r;
  logic [7:0] rx_sh_r;
  logic [7:0] tx_sh_r;
  logic [7:0] regs_r [NREGS];

  logic [7:0] rx_next_s;
  logic       byte_end_s;
  logic [6:0] rd_addr_s;
  logic [7:0] rd_data_s;
  logic       commit_s;

  // Shift-in value, read-address selection and SPI write-commit qualification
  always_comb begin
    rx_next_s  = {rx_sh_r[6:0], sdi_s};
    byte_end_s = sclk_rise && (bit_cnt_r == 3'd7);
    rd_addr_s  = 7'h00;
    rd_data_s  = 8'h00;
    commit_s   = 1'b0;
    // After the address byte the first fetch uses the just-received address, later fetches addr+1
    if (state_r == ADDR) begin
      rd_addr_s = rx_next_s[6:0];
    end else begin
      rd_addr_s = addr_r + 7'd1;
    end
    if (rd_addr_s == WHOAMI_ADDR) begin
      rd_data_s = WHOAMI_VAL;
    end else if ({1'b0, rd_addr_s} < NREGS_W) begin
      rd_data_s = regs_r[rd_addr_s[AW-1:0]];
    end else begin
      rd_data_s = 8'h00;
    end
    commit_s = (state_r == DATA) && (rw_r != RW_READ) && byte_end_s && !cs_rise &&
               ({1'b0, addr_r} < NREGS_W) && (addr_r != WHOAMI_ADDR);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall) begin
          state_next = ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      ADDR: begin
        if (cs_rise) begin
          state_next = IDLE;
        end else if (byte_end_s) begin
          state_next = DATA;
        end else begin
          state_next = ADDR;
        end
      end
      DATA: begin
        if (cs_rise) begin
          state_next = IDLE;
        end else begin
          state_next = DATA;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Serial datapath: bit/byte counting, address capture, tx shifter and event pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt_r   <= 3'd0;
      addr_r      <= 7'h00;
      rw_r        <= 1'b0;
      byte_seen_r <= 1'b0;
      rx_sh_r     <= 8'h00;
      tx_sh_r     <= 8'h00;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      wr_valid    <= 1'b0;
      wr_addr     <= 7'h00;
      wr_data     <= 8'h00;
      frame_done  <= 1'b0;
    end else begin
      wr_valid   <= 1'b0;
      frame_done <= 1'b0;
      if (cs_rise) begin
        sdo         <= 1'b0;
        sdo_oe      <= 1'b0;
        bit_cnt_r   <= 3'd0;
        byte_seen_r <= 1'b0;
        frame_done  <= (state_r != IDLE) && byte_seen_r;
      end else if (state_r == IDLE) begin
        bit_cnt_r   <= 3'd0;
        byte_seen_r <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_sh_r   <= rx_next_s;
          bit_cnt_r <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            byte_seen_r <= 1'b1;
            if (state_r == ADDR) begin
              rw_r    <= rx_next_s[7];
              addr_r  <= rx_next_s[6:0];
              tx_sh_r <= rd_data_s;
            end else if (rw_r == RW_READ) begin
              addr_r  <= addr_r + 7'd1;
              tx_sh_r <= rd_data_s;
            end else begin
              wr_valid <= 1'b1;
              wr_addr  <= addr_r;
              wr_data  <= rx_next_s;
              addr_r   <= addr_r + 7'd1;
            end
          end
        end
        if (sclk_fall && (state_r == DATA) && (rw_r == RW_READ)) begin
          sdo     <= tx_sh_r[7];
          tx_sh_r <= {tx_sh_r[6:0], 1'b0};
          sdo_oe  <= 1'b1;
        end
      end
    end
  end

  // Register file; the host write is last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      if (commit_s) begin
        regs_r[addr_r[AW-1:0]] <= rx_next_s;
      end
      if (host_we) begin
        regs_r[host_addr] <= host_wdata;
      end
    end
  end

endmodule

// File: tb/tb_spi_imu_responder.sv
// Self-checking bench for spi_imu_responder: directed scenarios then randomized frames,
// all checked against a byte-level model of the register file and the SPI protocol.
module tb_spi_imu_responder;

  logic       clk = 1'b0;
  logic       reset, cs, sclk, sdi, host_we;
  logic [3:0] host_addr;
  logic [7:0] host_wdata;
  logic       sdo, sdo_oe, wr_valid, frame_done;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  spi_imu_responder dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .sdi(sdi), .sdo(sdo), .sdo_oe(sdo_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mregs [16];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];
  logic       oe_buf [8];
  logic [6:0] wa_q [$];
  logic [7:0] wd_q [$];
  int         fd_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    if (a == 7'h0F) return 8'h68;
    if (a < 7'd16) return mregs[a[3:0]];
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (wr_valid) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
    if (frame_done) fd_cnt++;
  end

  task automatic shift_bit(input logic v, output logic got, output logic oe);
    sclk = 1'b0;
    sdi  = v;
    repeat (4) @(negedge clk);
    got  = sdo;
    oe   = sdo_oe;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_xfer(input int nb, input int extra);
    logic g, o;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      for (int b = 7; b >= 0; b--) begin
        shift_bit(tx_buf[i][b], g, o);
        rx_buf[i][b] = g;
        if (b == 0) oe_buf[i] = o;
      end
    end
    for (int e = 0; e < extra; e++) shift_bit(1'($urandom_range(0, 1)), g, o);
    repeat (2) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    @(negedge clk);
    host_we    = 1'b0;
    mregs[a]   = d;
  endtask

  // Address byte {rw,a}, then nd data bytes from tx_buf[1..], then extra partial bits
  task automatic run_frame(input logic rw, input logic [6:0] a, input int nd, input int extra);
    int         wb, fb;
    logic [6:0] ea;
    logic [7:0] exp_rd [8];
    tx_buf[0] = {rw, a};
    wb = wa_q.size();
    fb = fd_cnt;
    for (int j = 0; j < nd; j++) exp_rd[j] = model_read(a + 7'(j));
    spi_xfer(nd + 1, extra);
    check_eq("addr_oe", 32'(oe_buf[0]), 32'd0);
    for (int j = 0; j < nd; j++) begin
      ea = a + 7'(j);
      if (rw) begin
        check_eq("rd_data", 32'(rx_buf[j+1]), 32'(exp_rd[j]));
        check_eq("rd_oe", 32'(oe_buf[j+1]), 32'd1);
      end else begin
        check_eq("wr_oe", 32'(oe_buf[j+1]), 32'd0);
        if (wb + j < wa_q.size()) begin
          check_eq("wr_addr", 32'(wa_q[wb+j]), 32'(ea));
          check_eq("wr_data", 32'(wd_q[wb+j]), 32'(tx_buf[j+1]));
        end
        if (ea < 7'd16 && ea != 7'h0F) mregs[ea[3:0]] = tx_buf[j+1];
      end
    end
    check_eq("wr_count", 32'(wa_q.size() - wb), rw ? 32'd0 : 32'(nd));
    check_eq("frame_done", 32'(fd_cnt - fb), 32'd1);
  endtask

  initial begin
    logic       g, o, rw;
    logic [6:0] a;
    logic [7:0] who;
    int         nd, ex, fb, wb;

    reset = 1'b0; cs = 1'b1; sclk = 1'b1; sdi = 1'b0;
    host_we = 1'b0; host_addr = 4'd0; host_wdata = 8'h00;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    repeat (5) @(negedge clk);
    check_eq("rst_sdo", 32'(sdo), 32'd0);
    check_eq("rst_oe", 32'(sdo_oe), 32'd0);
    check_eq("rst_wr_valid", 32'(wr_valid), 32'd0);
    check_eq("rst_frame_done", 32'(frame_done), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // WHOAMI read
    run_frame(1'b1, 7'h0F, 1, 0);
    // host load, read with auto-increment over an untouched register
    host_write(4'h0, 8'h11);
    host_write(4'h1, 8'h22);
    run_frame(1'b1, 7'h00, 3, 0);
    // write burst then read back
    tx_buf[1] = 8'hA5; tx_buf[2] = 8'h3C;
    run_frame(1'b0, 7'h02, 2, 0);
    run_frame(1'b1, 7'h02, 2, 0);
    // out-of-range write with wrap, then read-only WHOAMI
    tx_buf[1] = 8'hFF; tx_buf[2] = 8'hEE;
    run_frame(1'b0, 7'h7F, 2, 0);
    run_frame(1'b1, 7'h7F, 2, 0);
    tx_buf[1] = 8'h55;
    run_frame(1'b0, 7'h0F, 1, 0);
    run_frame(1'b1, 7'h0F, 1, 0);
    // abort after 5 data bits
    run_frame(1'b0, 7'h04, 0, 5);
    run_frame(1'b1, 7'h04, 1, 0);
    // partial address byte only: no frame_done
    fb = fd_cnt;
    wb = wa_q.size();
    spi_xfer(0, 3);
    check_eq("partial_fd", 32'(fd_cnt - fb), 32'd0);
    check_eq("partial_wr", 32'(wa_q.size() - wb), 32'd0);

    // reset during the 3rd data bit of a WHOAMI read
    fb = fd_cnt;
    who = 8'h68;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 7; b >= 0; b--) shift_bit(b == 7 || b <= 3, g, o);
    shift_bit(1'b0, g, o);
    shift_bit(1'b0, g, o);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("pre_rst_sdo", 32'(sdo), 32'(who[5]));
    check_eq("pre_rst_oe", 32'(sdo_oe), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_sdo", 32'(sdo), 32'd0);
    check_eq("midrst_oe", 32'(sdo_oe), 32'd0);
    reset = 1'b1;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    shift_bit(1'b1, g, o);
    check_eq("post_rst_oe", 32'(o), 32'd0);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("post_rst_fd", 32'(fd_cnt - fb), 32'd0);
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    run_frame(1'b1, 7'h0F, 1, 0);
    run_frame(1'b1, 7'h00, 4, 0);

    // randomized frames
    for (int k = 0; k < 50; k++) begin
      if ($urandom_range(0, 3) == 0) host_write(4'($urandom_range(0, 15)), 8'($urandom));
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 7'h7C + 7'($urandom_range(0, 3));
      else a = 7'($urandom_range(0, 19));
      nd = $urandom_range(0, 4);
      ex = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int j = 1; j <= nd; j++) tx_buf[j] = 8'($urandom);
      run_frame(rw, a, nd, ex);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_imu_responder.md
Name: spi_imu_responder

Overview:
- SPI mode-3 responder that emulates the IMU on the stabilizer's IMU link. It is the peripheral end of the link; the stabilizer's SPI master is the initiator.
- Holds a small byte register file. The master reads and writes it over cs/sclk/sdi/sdo.
- A host side port loads the sensor-data registers, so simulation and FPGA self-test can close the loop without a real IMU.

Parameters:
- NREGS, 16, register file depth in bytes. Addresses 0..NREGS-1 are implemented.
- WHOAMI_ADDR, 7'h0F, address of the read-only ID register.
- WHOAMI_VAL, 8'h68, value returned at WHOAMI_ADDR.

Ports:
- clk  in  1  system clock. Must be at least 4x the sclk frequency.
- reset  in  1  synchronous reset, active-low (asserted when 0).
- cs  in  1  chip select from master, active-low.
- sclk  in  1  SPI clock from master; idles high (CPOL=1, CPHA=1).
- sdi  in  1  serial data from master (the master's SDI-into-IMU line).
- sdo  out  1  serial data to master.
- sdo_oe  out  1  high while the responder is driving read data.
- host_we  in  1  host write strobe.
- host_addr  in  $clog2(NREGS)  host write address.
- host_wdata  in  8  host write data.
- wr_valid  out  1  one-cycle pulse when an SPI write commits a byte.
- wr_addr  out  7  address of the committed SPI write.
- wr_data  out  8  data of the committed SPI write.
- frame_done  out  1  one-cycle pulse when cs deasserts after at least one complete byte.

Behaviour:
- **Reset** (reset==0 at a clk edge):
  - State goes to IDLE.
  - All registers clear to 8'h00; WHOAMI reads WHOAMI_VAL.
  - sdo=0, sdo_oe=0, wr_valid=0, frame_done=0, bit and byte counters clear.
  - Reset mid-frame aborts the frame. The responder stays in IDLE until cs is seen high, then low again.
- **Input synchronisation**:
  - cs, sclk and sdi each pass through a 2-flop synchroniser of equal depth.
  - sclk rise/fall events are single-cycle pulses derived from the synchronised value.
- **Sampling**: sdi is sampled on the sclk rise event, MSB first. sdo changes only on a sclk fall event, registered one clk later. Pin-to-sdo latency is 3 clk.
- **FSM states**:
  - IDLE → ADDR when synchronised cs falls.
  - ADDR: shift 8 bits. bit7 is RW (1=read); bits 6:0 are the address. After bit 8, go to DATA.
    - Read: load tx byte = reg[addr]. Its MSB is driven on the next fall event, and sdo_oe=1 from that point.
    - Write: nothing is driven.
  - DATA, write: every 8 received bits commits reg[addr] <= byte, pulses wr_valid, then addr++.
  - DATA, read: after 8 bits shifted out, addr++ and reload the tx byte from the new address before the next fall event.
  - Any state → IDLE on cs rise: sdo_oe=0, sdo=0. frame_done pulses if at least one complete byte was shifted. A partial byte is discarded and no write commits.
- **Address rules**:
  - Address is 7 bits and wraps 7'h7F → 7'h00.
  - addr >= NREGS: reads return 8'h00; writes are ignored but still pulse wr_valid.
  - WHOAMI_ADDR is read-only. SPI writes to it are ignored but still pulse wr_valid.
- **Host port**:
  - host_we writes reg[host_addr] in the same cycle.
  - If a host write and an SPI commit hit the same address in the same cycle, the host write wins.
  - A host write to a byte already loaded into the tx shifter does not change the byte in flight.
- **cs glitch**: cs low for fewer than 2 clk may be missed. This is acceptable.

Decomposition:
- Package spi_imu_pkg holds:
  - state enum (IDLE, ADDR, DATA);
  - RW_READ constant;
  - WHOAMI defaults.
- One sub-module, edge_sync: a 2-flop synchroniser with rise/fall pulse outputs, instantiated for cs and sclk. sdi uses the same module with the pulse outputs unused.
- Register file and FSM stay in the top module.

Test Plan:
1. Release reset, read 0x0F: cs low, shift 8'h8F then 8 dummy clocks → sdo byte = 8'h68, sdo_oe high during the data byte, frame_done pulses once after cs rises.
2. Write burst: shift 8'h02, 8'hA5, 8'h3C → wr_valid twice (addr 0x02 data A5, addr 0x03 data 3C); a later read burst from 0x82 returns A5, 3C.
3. Host load then read with auto-increment: host writes 0x00=11, 0x01=22; SPI read from 0x80 for 3 bytes → 11, 22, 00.
4. Out-of-range and wrap: write 0x7F=FF, 0x00=EE in one burst → wr_valid for 0x7F (ignored), 0x00 commits EE; a write to 0x0F leaves WHOAMI at 68.
5. Abort: cs high after 5 data bits of a write to 0x04 → reg 0x04 unchanged, no wr_valid, frame_done pulses (address byte completed).
6. Reset mid-read: assert reset during the 3rd data bit → sdo=0 and sdo_oe=0 next clk, registers zero; a fresh frame then reads 0x0F correctly.
